// File: rtl/vfpu_pkg.sv
// Shared definitions for the vector FPU element sequencer.
//   - state encoding for the sequencer FSM
//   - FP32 field constants used by the overflow detector
package vfpu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } seq_state_t;

    localparam int         FP32_W       = 32;
    localparam logic [7:0] FP32_EXP_INF = 8'hff;

endpackage

// File: rtl/vfpu_tag_pipe.sv
// LAT-deep shift register of {valid, idx} tags that shadows the fixed-latency
// datapath. A tag entering with an issue leaves LAT cycles later, exactly
// when the matching result is on dp_res.
// Ports:
//   clk, rst             clock, async active-high clear
//   in_valid, in_idx     tag of the element issued this cycle
//   tag_valid, tag_idx   tag whose result is on dp_res this cycle
//   pipe_busy            any stage holds a valid tag
//   busy_next            some valid tag remains after this cycle's exit
module vfpu_tag_pipe #(
    parameter int LAT = 3,
    parameter int IW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          tag_valid,
    output logic [IW-1:0] tag_idx,
    output logic          pipe_busy,
    output logic          busy_next
);

    logic [LAT-1:0] vld;
    logic [IW-1:0]  idx [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) idx[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    // Occupancy once the last stage has been consumed this cycle; lets the
    // sequencer leave DRAIN on the same edge the final result is written.
    always_comb begin
        busy_next = in_valid;
        for (int i = 0; i < LAT - 1; i++) busy_next = busy_next | vld[i];
    end

    assign tag_valid = vld[LAT-1];
    assign tag_idx   = idx[LAT-1];
    assign pipe_busy = |vld;

endmodule

// File: rtl/vfpu_elem_seq.sv
// Element sequencer for the vector FPU add/round datapath. Accepts one vector
// command, issues its elements one per cycle, gathers the LAT-delayed results
// into a vector buffer and presents the completed vector on a valid/ready
// output.
// Optional feature macro: VFPU_ELEM_SEQ_EXC_EN enables the sticky overflow
// (+/-infinity result) flag on out_exc; otherwise out_exc is tied low.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_len, cmd_nj_mode          element count minus one, flush-denormal mode
//   dp_valid, dp_idx, dp_nj_mode  element issue toward the datapath
//   dp_res                        datapath result, LAT cycles after its issue
//   out_valid/out_ready           result vector handshake
//   out_data                      element i in bits [32i+31:32i]
//   out_exc                       sticky overflow flag
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | one element issued per cycle, indices 0..len
// DRAIN | waiting for in-flight results to land in the buffer
// DONE  | vector presented on out_valid until out_ready
module vfpu_elem_seq
    import vfpu_pkg::*;
#(
    parameter int VLEN = 4,
    parameter int LAT  = 3,
    localparam int IW  = $clog2(VLEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [IW-1:0]            cmd_len,
    input  logic                     cmd_nj_mode,
    output logic                     dp_valid,
    output logic [IW-1:0]            dp_idx,
    output logic                     dp_nj_mode,
    input  logic [FP32_W-1:0]        dp_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP32_W*VLEN-1:0]   out_data,
    output logic                     out_exc
);

    seq_state_t                   state_q, state_d;
    logic [IW-1:0]                len_q;
    logic [IW-1:0]                issue_cnt_q;
    logic                         nj_q;
    logic [VLEN-1:0][FP32_W-1:0]  res_buf;
    logic                         accept;
    logic                         drain_done;

    logic          tag_valid;
    logic [IW-1:0] tag_idx;
    logic          pipe_busy;
    logic          busy_next;

    vfpu_tag_pipe #(
        .LAT (LAT),
        .IW  (IW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (dp_valid),
        .in_idx    (dp_idx),
        .tag_valid (tag_valid),
        .tag_idx   (tag_idx),
        .pipe_busy (pipe_busy),
        .busy_next (busy_next)
    );

    // Leave DRAIN on the edge that writes the final result so out_valid
    // rises in the cycle right after it.
    assign drain_done = pipe_busy ? !busy_next : 1'b1;
    assign accept     = (state_q == S_IDLE) && cmd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        dp_valid  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                dp_valid = 1'b1;
                if (issue_cnt_q == len_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            issue_cnt_q <= '0;
            nj_q        <= 1'b0;
            res_buf     <= '0;
        end else if (accept) begin
            len_q       <= cmd_len;
            issue_cnt_q <= '0;
            nj_q        <= cmd_nj_mode;
            res_buf     <= '0;
        end else begin
            // Hold at len after the last issue so the index never wraps.
            if (state_q == S_ISSUE && issue_cnt_q != len_q)
                issue_cnt_q <= issue_cnt_q + 1'b1;
            if (tag_valid)
                res_buf[tag_idx] <= dp_res;
        end
    end

`ifdef VFPU_ELEM_SEQ_EXC_EN
    logic exc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            exc_q <= 1'b0;
        else if (accept)
            exc_q <= 1'b0;
        else if (tag_valid && dp_res[30:23] == FP32_EXP_INF && dp_res[22:0] == '0)
            exc_q <= 1'b1;
    end

    assign out_exc = exc_q;
`else
    assign out_exc = 1'b0;
`endif

    assign dp_idx     = issue_cnt_q;
    assign dp_nj_mode = nj_q;
    assign out_data   = res_buf;

endmodule
